phase_peak_detector: RTL

- Front end that produces the per-window phase-C voltage and current peak magnitudes consumed by the fault classification stage.
- Accepts a stream of signed ADC samples with a valid strobe.
- Tracks saturating absolute-value maxima over fixed windows of WINDOW_LEN accepted samples.
- At each window boundary, registers Vc_peak/Ic_peak with a one-cycle peak_valid strobe; values hold until the next window completes.

---
 rtl/fault_pkg.sv | 41 ++++
 rtl/abs_max_tracker.sv | 70 +++++++
 rtl/phase_peak_detector.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fault_pkg.sv
// ----------------------------------------------------------------------------
// fault_pkg
// Shared definitions for the phase-C peak front end and the fault classifier.
//   DATA_W / MAG_W : sample width and magnitude width (sign bit dropped)
//   NORMAL/FAULT1  : fault codes used by the classifier and downstream users
//   sat_abs()      : saturating absolute value with saturation indication
// ----------------------------------------------------------------------------
package fault_pkg;

   localparam int DATA_W = 16;
   localparam int MAG_W  = DATA_W - 1;

   localparam logic [2:0] NORMAL = 3'b000;
   localparam logic [2:0] FAULT1 = 3'b001;

   typedef struct packed {
      logic             sat;
      logic [MAG_W-1:0] mag;
   } sat_abs_t;

   // The most negative code has no positive twin, so it clamps to the
   // largest magnitude and raises sat. Negation only needs the low MAG_W
   // bits because the result is known to be non-negative.
   function automatic sat_abs_t sat_abs(input logic [DATA_W-1:0] x);
      sat_abs_t         r;
      logic [MAG_W-1:0] neg;
      neg = (~x[MAG_W-1:0]) + {{(MAG_W-1){1'b0}}, 1'b1};
      if (x[DATA_W-1] == 1'b0) begin
         r.mag = x[MAG_W-1:0];
         r.sat = 1'b0;
      end else if (x[MAG_W-1:0] == {MAG_W{1'b0}}) begin
         r.mag = {MAG_W{1'b1}};
         r.sat = 1'b1;
      end else begin
         r.mag = neg;
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/abs_max_tracker.sv
// ----------------------------------------------------------------------------
// abs_max_tracker
// Running saturating-|x| maximum and sticky saturation bit for one channel.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sample       : signed sample of this channel
//   accept       : sample is taken this cycle (already gated by clear)
//   window_end   : this accepted sample is the last one of the window
//   clear        : drop the partial window
//   next_max     : max(running max, |sample|), combinational
//   next_sat     : sticky sat OR saturation of sample, combinational
// ----------------------------------------------------------------------------
module abs_max_tracker
   import fault_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample,
   input  logic              accept,
   input  logic              window_end,
   input  logic              clear,
   output logic [MAG_W-1:0]  next_max,
   output logic              next_sat
);

   sat_abs_t         abs_s;
   logic [MAG_W-1:0] running_max_q, running_max_d;
   logic             sat_q, sat_d;

   // Candidate maximum including the current sample; ties keep the old value.
   always_comb begin
      abs_s = sat_abs(sample);
      if (abs_s.mag > running_max_q) begin
         next_max = abs_s.mag;
      end else begin
         next_max = running_max_q;
      end
      next_sat = sat_q | abs_s.sat;
   end

   // Next-state of the running maximum: cleared on discard or window end.
   always_comb begin
      running_max_d = running_max_q;
      sat_d         = sat_q;
      if (clear) begin
         running_max_d = {MAG_W{1'b0}};
         sat_d         = 1'b0;
      end else if (accept && window_end) begin
         running_max_d = {MAG_W{1'b0}};
         sat_d         = 1'b0;
      end else if (accept) begin
         running_max_d = next_max;
         sat_d         = next_sat;
      end else begin
         running_max_d = running_max_q;
         sat_d         = sat_q;
      end
   end

   // Running maximum and sticky saturation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_max_q <= {MAG_W{1'b0}};
         sat_q         <= 1'b0;
      end else begin
         running_max_q <= running_max_d;
         sat_q         <= sat_d;
      end
   end

endmodule

// File: rtl/phase_peak_detector.sv
// ----------------------------------------------------------------------------
// phase_peak_detector
// Per-window phase-C voltage/current peak magnitudes for fault classification.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous discard of the partial window (wins over samples)
//   sample_valid : Vc_sample / Ic_sample valid this cycle
//   Vc_sample    : signed phase-C voltage sample
//   Ic_sample    : signed phase-C current sample
//   Vc_peak      : max |Vc| of the last completed window (never negative)
//   Ic_peak      : max |Ic| of the last completed window (never negative)
//   peak_valid   : one-cycle pulse when new peaks are presented
//   sat_flag     : a full-scale negative sample occurred in that window
//   sample_cnt   : accepted samples in the current partial window
// DATA_W must match fault_pkg::DATA_W, since the trackers use the package width.
// ----------------------------------------------------------------------------
module phase_peak_detector #(
   parameter int DATA_W     = 16,
   parameter int WINDOW_LEN = 256,
   parameter int CNT_W      = $clog2(WINDOW_LEN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] Vc_sample,
   input  logic signed [DATA_W-1:0] Ic_sample,
   output logic signed [DATA_W-1:0] Vc_peak,
   output logic signed [DATA_W-1:0] Ic_peak,
   output logic                     peak_valid,
   output logic                     sat_flag,
   output logic [CNT_W-1:0]         sample_cnt
);

   import fault_pkg::*;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);

   logic             accept_s;
   logic             window_end_s;
   logic [MAG_W-1:0] vc_next_max_s, ic_next_max_s;
   logic             vc_next_sat_s, ic_next_sat_s;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] vc_peak_q, vc_peak_d;
   logic [DATA_W-1:0] ic_peak_q, ic_peak_d;
   logic              sat_q, sat_d;
   logic              pv_q, pv_d;

   // A sample only counts when clear is low; the last index closes the window.
   always_comb begin
      accept_s     = sample_valid & ~clear;
      window_end_s = accept_s & (cnt_q == LAST_IDX);
   end

   abs_max_tracker u_vc_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (Vc_sample),
      .accept     (accept_s),
      .window_end (window_end_s),
      .clear      (clear),
      .next_max   (vc_next_max_s),
      .next_sat   (vc_next_sat_s)
   );

   abs_max_tracker u_ic_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (Ic_sample),
      .accept     (accept_s),
      .window_end (window_end_s),
      .clear      (clear),
      .next_max   (ic_next_max_s),
      .next_sat   (ic_next_sat_s)
   );

   // Counter and output next-state; peaks include the window's final sample.
   always_comb begin
      cnt_d     = cnt_q;
      vc_peak_d = vc_peak_q;
      ic_peak_d = ic_peak_q;
      sat_d     = sat_q;
      pv_d      = 1'b0;
      if (window_end_s) begin
         cnt_d     = {CNT_W{1'b0}};
         vc_peak_d = {1'b0, vc_next_max_s};
         ic_peak_d = {1'b0, ic_next_max_s};
         sat_d     = vc_next_sat_s | ic_next_sat_s;
         pv_d      = 1'b1;
      end else if (accept_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter, held peak outputs and the peak_valid strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= {CNT_W{1'b0}};
         vc_peak_q <= {DATA_W{1'b0}};
         ic_peak_q <= {DATA_W{1'b0}};
         sat_q     <= 1'b0;
         pv_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         vc_peak_q <= vc_peak_d;
         ic_peak_q <= ic_peak_d;
         sat_q     <= sat_d;
         pv_q      <= pv_d;
      end
   end

   assign Vc_peak    = vc_peak_q;
   assign Ic_peak    = ic_peak_q;
   assign sat_flag   = sat_q;
   assign peak_valid = pv_q;
   assign sample_cnt = cnt_q;

endmodule
